// File: rtl/vote_tally.sv
// Session-based ballot counter: opens on start, tallies one ballot per
// voter, closes on request, when everyone has voted, or on timeout.
module vote_tally #(
  parameter int N       = 4,
  parameter int QUORUM  = 3,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  I,
  input  logic [N-1:0]  V,
  input  logic          close,
  output logic [CW-1:0] O_yes,
  output logic [CW-1:0] O_cast,
  output logic          O_busy,
  output logic          O_done,
  output logic          O_pass,
  output logic          O_reject,
  output logic          O_tie,
  output logic          O_noq
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT-1);
  localparam logic [CW-1:0] QW    = CW'(QUORUM);

  typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] yes_q, yes_d;
  logic [CW-1:0] cast_q, cast_d;
  logic          res_vld_q, res_vld_d;
  logic [N-1:0]  acc;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] x);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + CW'(x[i]);
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    timer_d   = timer_q;
    yes_d     = yes_q;
    cast_d    = cast_q;
    res_vld_d = res_vld_q;
    acc       = I & ~mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = OPEN;
          mask_d    = '0;
          timer_d   = '0;
          yes_d     = '0;
          cast_d    = '0;
          res_vld_d = 1'b0;
        end
      end
      OPEN: begin
        yes_d   = yes_q + popcnt(acc & V);
        cast_d  = cast_q + popcnt(acc);
        mask_d  = mask_q | acc;
        timer_d = timer_q + 1'b1;
        // Ballots landing on the closing edge still count.
        if (close || (&(mask_q | acc)) || timer_q == TLAST) begin
          state_d   = DONE;
          res_vld_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      yes_q     <= '0;
      cast_q    <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      yes_q     <= yes_d;
      cast_q    <= cast_d;
      res_vld_q <= res_vld_d;
    end
  end

  always_comb begin
    O_pass   = 1'b0;
    O_reject = 1'b0;
    O_tie    = 1'b0;
    O_noq    = 1'b0;
    if (res_vld_q) begin
      if (cast_q < QW) begin
        O_noq = 1'b1;
      end else begin
        O_pass   = {yes_q, 1'b0} >  {1'b0, cast_q};
        O_tie    = {yes_q, 1'b0} == {1'b0, cast_q};
        O_reject = {yes_q, 1'b0} <  {1'b0, cast_q};
      end
    end
  end

  assign O_yes  = yes_q;
  assign O_cast = cast_q;
  assign O_busy = (state_q == OPEN);
  assign O_done = (state_q == DONE);

endmodule
